// File: rtl/crc_scrub_pkg.sv
// rtl/crc_scrub_pkg.sv - shared types and constants for the CRC-8 memory scrubber
package crc_scrub_pkg;

   localparam logic [7:0] CRC_POLY_DEFAULT = 8'h97;
   localparam int DATA_W = 24;
   localparam int CRC_W  = 8;
   localparam int WORD_W = DATA_W + CRC_W;
   localparam int IDX_W  = $clog2(WORD_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CHECK,
      ST_SEARCH,
      ST_WR,
      ST_NEXT,
      ST_DONE
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/crc_scrubber_if.sv
// rtl/crc_scrubber_if.sv - scrubber memory request/ack bus
interface crc_scrubber_if
   import crc_scrub_pkg::*;
#(
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/crc8_comb.sv
// rtl/crc8_comb.sv - combinational MSB-first CRC-8 over a 24-bit data field
module crc8_comb
   import crc_scrub_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEFAULT
) (
   input  logic [DATA_W-1:0] data,
   output logic [CRC_W-1:0]  crc
);
   logic [CRC_W-1:0] r;

   always_comb begin
      r = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (r[CRC_W-1] ^ data[i]) begin
            r = {r[CRC_W-2:0], 1'b0} ^ POLY;
         end else begin
            r = {r[CRC_W-2:0], 1'b0};
         end
      end
   end

   assign crc = r;
endmodule

// File: rtl/crc_scrubber.sv
// rtl/crc_scrubber.sv - background scrubber: read, check, single-bit repair, write back
module crc_scrubber
   import crc_scrub_pkg::*;
#(
   parameter int               ADDR_W    = 8,
   parameter int               LAST_ADDR = 2**ADDR_W - 1,
   parameter logic [CRC_W-1:0] CRC_POLY  = CRC_POLY_DEFAULT
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   crc_scrubber_if.master    mem,
   output logic [15:0]       corr_cnt,
   output logic [15:0]       uncorr_cnt,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_flag
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] w_q, w_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [15:0]       corr_q, corr_d;
   logic [15:0]       uncorr_q, uncorr_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              err_flag_q, err_flag_d;

   logic [CRC_W-1:0]  crc_w, crc_c;
   logic [CRC_W-1:0]  syn_w, syn_c;
   logic [WORD_W-1:0] cand;

   // The candidate flips exactly one bit of the captured word per SEARCH cycle.
   assign cand = w_q ^ (WORD_W'(1) << idx_q);

   crc8_comb #(.POLY(CRC_POLY)) u_crc_word (
      .data (w_q[WORD_W-1:CRC_W]),
      .crc  (crc_w)
   );

   crc8_comb #(.POLY(CRC_POLY)) u_crc_cand (
      .data (cand[WORD_W-1:CRC_W]),
      .crc  (crc_c)
   );

   assign syn_w = crc_w ^ w_q[CRC_W-1:0];
   assign syn_c = crc_c ^ cand[CRC_W-1:0];

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      w_d        = w_q;
      idx_d      = idx_q;
      corr_d     = corr_q;
      uncorr_d   = uncorr_q;
      err_addr_d = err_addr_q;
      err_flag_d = err_flag_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               corr_d     = '0;
               uncorr_d   = '0;
               err_flag_d = 1'b0;
               addr_d     = '0;
               state_d    = ST_RD;
            end
         end
         ST_RD: begin
            if (mem.mem_ack) begin
               w_d     = mem.mem_rdata;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (syn_w == '0) begin
               state_d = ST_NEXT;
            end else begin
               idx_d   = '0;
               state_d = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (syn_c == '0) begin
               w_d     = cand;
               corr_d  = sat_inc16(corr_q);
               state_d = ST_WR;
            end else if (idx_q == IDX_W'(WORD_W - 1)) begin
               uncorr_d   = sat_inc16(uncorr_q);
               err_addr_d = addr_q;
               err_flag_d = 1'b1;
               state_d    = ST_NEXT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_WR: begin
            if (mem.mem_ack) begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (addr_q == LAST) begin
               state_d = ST_DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_RD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         w_q        <= '0;
         idx_q      <= '0;
         corr_q     <= '0;
         uncorr_q   <= '0;
         err_addr_q <= '0;
         err_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         w_q        <= w_d;
         idx_q      <= idx_d;
         corr_q     <= corr_d;
         uncorr_q   <= uncorr_d;
         err_addr_q <= err_addr_d;
         err_flag_q <= err_flag_d;
      end
   end

   // Bus outputs decode straight from the state flop so reset drops mem_req at once.
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);
   assign mem.mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
   assign mem.mem_we    = (state_q == ST_WR);
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = w_q;

   assign corr_cnt   = corr_q;
   assign uncorr_cnt = uncorr_q;
   assign err_addr   = err_addr_q;
   assign err_flag   = err_flag_q;
endmodule

// File: tb/tb_crc_scrubber.sv
// tb/tb_crc_scrubber.sv - randomized self-checking bench for crc_scrubber
module tb_crc_scrubber;
   import crc_scrub_pkg::*;

   localparam int AW   = 4;
   localparam int LAST = 3;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, err_flag;
   logic [15:0]   corr_cnt, uncorr_cnt;
   logic [AW-1:0] err_addr;

   crc_scrubber_if #(.ADDR_W(AW)) bus ();

   logic [31:0] mem [2**AW];
   int          wait_states = 0;
   int          wcnt;

   assign bus.mem_ack   = bus.mem_req && (wcnt == wait_states);
   assign bus.mem_rdata = mem[bus.mem_addr];

   crc_scrubber #(.ADDR_W(AW), .LAST_ADDR(LAST), .CRC_POLY(8'h97)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .mem        (bus.master),
      .corr_cnt   (corr_cnt),
      .uncorr_cnt (uncorr_cnt),
      .err_addr   (err_addr),
      .err_flag   (err_flag)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK or posedge reset) begin
      if (reset) wcnt <= 0;
      else if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Syndrome as the remainder of the whole 32-bit word polynomial modulo x^8+P.
   function automatic logic [7:0] pmod(input logic [31:0] w);
      logic [31:0] r;
      r = w;
      for (int i = 31; i >= 8; i--) if (r[i]) r = r ^ (32'h197 << (i - 8));
      return r[7:0];
   endfunction

   function automatic logic [31:0] make_word(input int kind);
      logic [31:0] w;
      int p1, p2;
      w = {$urandom() & 32'h00FF_FFFF} << 8;
      w[7:0] = pmod(w);
      p1 = $urandom_range(0, 31);
      p2 = (p1 + $urandom_range(1, 31)) % 32;
      if (kind >= 1) w = w ^ (32'd1 << p1);
      if (kind == 2) w = w ^ (32'd1 << p2);
      return w;
   endfunction

   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];
   logic [AW-1:0] m_err_addr = '0;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [31:0]   prev_wdata;
   logic          prev_we;

   // One cycle: advance to the falling edge, log completed writes, check bus stability.
   task automatic step();
      @(negedge CLK);
      if (!reset && prev_stall && bus.mem_req) begin
         check("stable_addr", 32'(bus.mem_addr), 32'(prev_addr));
         check("stable_we", 32'(bus.mem_we), 32'(prev_we));
         check("stable_wdata", bus.mem_wdata, prev_wdata);
      end
      prev_stall = !reset && bus.mem_req && !bus.mem_ack;
      prev_addr  = bus.mem_addr;
      prev_we    = bus.mem_we;
      prev_wdata = bus.mem_wdata;
      if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
         wa_q.push_back(bus.mem_addr);
         wd_q.push_back(bus.mem_wdata);
         mem[bus.mem_addr] = bus.mem_wdata;
      end
   endtask

   task automatic run_pass(input int w_st, input bit mid_start, input string tag);
      logic [AW-1:0] ewa[$];
      logic [31:0]   ewd[$];
      logic [31:0]   emem [LAST+1];
      logic [31:0]   w;
      int cycles, ec, eu, found, cyc;
      logic ef;
      cycles = 0; ec = 0; eu = 0; ef = 1'b0;
      wait_states = w_st;
      wa_q.delete();
      wd_q.delete();
      for (int a = 0; a <= LAST; a++) begin
         w = mem[a];
         emem[a] = w;
         cycles += 3 + w_st;
         if (pmod(w) != 8'h00) begin
            found = -1;
            for (int p = 0; p < 32; p++)
               if (found < 0 && pmod(w ^ (32'd1 << p)) == 8'h00) found = p;
            if (found >= 0) begin
               cycles += found + 2 + w_st;
               emem[a] = w ^ (32'd1 << found);
               ewa.push_back(AW'(a));
               ewd.push_back(emem[a]);
               ec++;
            end else begin
               cycles += 32;
               eu++;
               ef = 1'b1;
               m_err_addr = AW'(a);
            end
         end
      end

      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, "_req_rise"}, 32'(bus.mem_req), 32'd1);
      check({tag, "_first_addr"}, 32'(bus.mem_addr), 32'd0);
      cyc = 1;
      while (!done && cyc < 1000) begin
         start = (mid_start && cyc == 6);
         step();
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_cycle"}, 32'(cyc), 32'(cycles + 1));
      check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(ec));
      check({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(eu));
      check({tag, "_err_flag"}, 32'(err_flag), 32'(ef));
      check({tag, "_err_addr"}, 32'(err_addr), 32'(m_err_addr));
      step();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_n_writes"}, 32'(wa_q.size()), 32'(ewa.size()));
      for (int i = 0; i < ewa.size() && i < wa_q.size(); i++) begin
         check({tag, "_wr_addr"}, 32'(wa_q[i]), 32'(ewa[i]));
         check({tag, "_wr_data"}, wd_q[i], ewd[i]);
      end
      for (int a = 0; a <= LAST; a++) check({tag, "_mem"}, mem[a], emem[a]);
   endtask

   initial begin
      for (int a = 0; a < 2**AW; a++) mem[a] = 32'h0000_0197;
      reset = 1'b1;
      step();
      step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_req", 32'(bus.mem_req), 32'd0);
      check("rst_we", 32'(bus.mem_we), 32'd0);
      check("rst_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);
      check("rst_corr", 32'(corr_cnt), 32'd0);
      check("rst_uncorr", 32'(uncorr_cnt), 32'd0);
      check("rst_err_addr", 32'(err_addr), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);
      reset = 1'b0;
      step();

      run_pass(0, 1'b0, "clean");
      mem[2] = 32'h0000_0097;
      run_pass(0, 1'b0, "data_bit");
      mem[1] = 32'h0000_0001;
      run_pass(0, 1'b0, "crc_bit");
      mem[3] = 32'h0000_0003;
      run_pass(0, 1'b0, "double");

      for (int a = 0; a <= LAST; a++) mem[a] = make_word(a % 3);
      run_pass(3, 1'b1, "wait");

      for (int n = 0; n < 6; n++) begin
         for (int a = 0; a <= LAST; a++) mem[a] = make_word($urandom_range(0, 2));
         run_pass($urandom_range(0, 2), 1'b0, "rand");
      end

      mem[0] = 32'h0000_0097;
      mem[1] = 32'h0000_0003;
      mem[2] = 32'h0000_0197;
      mem[3] = 32'h0000_0197;
      wait_states = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (19) step();
      check("pre_rst_corr", 32'(corr_cnt), 32'd1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_req", 32'(bus.mem_req), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_corr", 32'(corr_cnt), 32'd0);
      check("async_rst_uncorr", 32'(uncorr_cnt), 32'd0);
      m_err_addr = '0;
      step();
      reset = 1'b0;
      step();
      check("rst_repaired_word", mem[0], 32'h0000_0197);
      run_pass(0, 1'b0, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/crc_scrubber.md
# crc_scrubber

Background memory scrubber for CRC-protected 32-bit words, the consumer side of the EDAC write path. On `start` it walks an address range and reads each stored codeword. It recomputes CRC-8 (poly 0x97) and corrects any single-bit error by a bit-serial search, then writes the repaired word back. Uncorrectable words are counted and flagged, never written.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width.
- `LAST_ADDR`, 2**ADDR_W-1: final address of a pass. The pass starts at 0.
- `CRC_POLY`, 8'h97: CRC-8 polynomial, without the implicit x^8.

Ports:
- `CLK`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a pass. Ignored while `busy`=1.
- `busy`  out  1: a pass is in progress.
- `done`  out  1: one-cycle pulse at the end of a pass.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: 1 = write, 0 = read.
- `mem_addr`  out  ADDR_W: request address.
- `mem_wdata`  out  32: write data.
- `mem_rdata`  in  32: read data. Valid when `mem_ack`=1 during a read.
- `mem_ack`  in  1: request accepted. For reads, data is valid at the same time.
- `corr_cnt`  out  16: corrected words this pass. Saturates at 0xFFFF.
- `uncorr_cnt`  out  16: uncorrectable words this pass. Saturates at 0xFFFF.
- `err_addr`  out  ADDR_W: address of the most recent uncorrectable word.
- `err_flag`  out  1: sticky. Set on an uncorrectable word, cleared by `start`.

## Operation
- Codeword layout: {data[23:0], crc[7:0]}, with data in bits 31:8.
- CRC definition: data processed MSB-first, init 0x00, no reflection, no final XOR.
- Syndrome S = crc8(w[31:8]) ^ w[7:0].
  - S = 0: word is clean.
  - A single-bit error at bit p yields a fixed nonzero S. For p < 8, S = 1<<p. For p ≥ 8, S = x^p mod P.
  - All 32 single-bit syndromes are distinct.
- FSM states: IDLE, RD, CHECK, SEARCH, WR, NEXT, DONE.
- IDLE:
  - On `start`: clear the counters and `err_flag`, set addr = 0, go to RD.
- RD:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=addr.
  - On `mem_ack`: capture `mem_rdata` into w and go to CHECK.
- CHECK:
  - S = 0: go to NEXT.
  - S ≠ 0: set idx = 0 and go to SEARCH.
- SEARCH:
  - Each cycle, test candidate c = w ^ (1<<idx).
  - If syndrome(c) = 0: set w = c, increment `corr_cnt`, go to WR.
  - Else if idx = 31: increment `uncorr_cnt`, set `err_addr` = addr and `err_flag` = 1, go to NEXT.
  - Else: idx = idx + 1.
- WR:
  - Drive `mem_req`=1, `mem_we`=1, `mem_wdata`=w.
  - On `mem_ack`: go to NEXT.
- NEXT:
  - If addr = LAST_ADDR: go to DONE. Otherwise increment addr and go to RD.
- DONE:
  - Assert `done` for one cycle, then go to IDLE.
- Handshake rules:
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1 and `mem_ack`=0.
  - `mem_req` drops in the cycle after ack.
  - `mem_ack` is ignored when `mem_req`=0.
- `busy`=1 in every state except IDLE. `start` during a pass has no effect.

## Timing
- Reset values: all outputs 0, and the FSM is in IDLE. Reset takes effect immediately, including mid-transaction, and `mem_req` drops asynchronously.
- `mem_req` rises in the cycle after `start` is sampled.
- Clean word with a zero-wait memory: RD, CHECK, NEXT = 3 cycles.
- Error at bit p: adds p+1 SEARCH cycles plus 1 WR cycle with zero-wait memory.
- Uncorrectable word: adds 32 SEARCH cycles and no write.
- `done` rises 1 cycle after NEXT for the last address.
- Counters update on the transition out of SEARCH. Saturation holds 0xFFFF with no wrap.
- The addr counter never wraps within a pass. LAST_ADDR terminates the pass.

## Structure
- Package `crc_scrub_pkg`:
  - FSM state enum.
  - `CRC_POLY_DEFAULT` = 8'h97.
  - Codeword field widths (DATA_W = 24, CRC_W = 8).
- Sub-module `crc8_comb`: combinational 24-bit to 8-bit CRC. It is parameterised by polynomial.
  - Instance 1 computes S on w.
  - Instance 2 computes the syndrome of the SEARCH candidate.

## Test plan
- Clean word: memory all 0x00000197, LAST_ADDR = 3, zero-wait.
  - Expect 4 reads and no writes.
  - `corr_cnt` = 0 and `done` at cycle 13 after `start`.
- Single data-bit error: addr 2 = 0x00000097.
  - Expect a write of 0x00000197 to addr 2 after 9 SEARCH cycles.
  - `corr_cnt` = 1.
- Single CRC-bit error: 0x00000001 (clean value 0x00000000).
  - Expect 1 SEARCH cycle, then a write of 0x00000000.
- Double error: 0x00000003, syndrome 0x03.
  - Expect no write and `uncorr_cnt` = 1.
  - Expect `err_addr` = that address and `err_flag` = 1.
- Wait-state handshake: `mem_ack` delayed by 3 cycles.
  - `mem_req`, `mem_addr` and `mem_wdata` stay stable throughout.
  - A `start` pulse mid-pass is ignored.
- Async reset asserted during SEARCH:
  - `mem_req`, `busy` and the counters go to 0 immediately.
  - The next `start` begins a pass at addr 0.
